// File: rtl/delay_sweep_sched_pkg.sv
// Shared types and helpers for the inter-pulse delay sweep scheduler.
// The saturating adder is DW_DEF bits wide so pulse-width sweeps can reuse it.
package delay_sweep_sched_pkg;

  localparam int DW_DEF = 16;
  localparam int NW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Returns {saturated, value}; value clamps to all-ones on carry out.
  function automatic logic [DW_DEF:0] sat_add(input logic [DW_DEF-1:0] a,
                                              input logic [DW_DEF-1:0] b);
    logic [DW_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DW_DEF]) begin
      sat_add = {1'b1, {DW_DEF{1'b1}}};
    end else begin
      sat_add = {1'b0, sum[DW_DEF-1:0]};
    end
  endfunction

endpackage

// File: rtl/delay_sweep_sched_sweep_counter.sv
// Shot/step counter pair for the delay sweep; terminal counts are (n-1).
module sweep_counter
  import delay_sweep_sched_pkg::*;
#(
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [NW-1:0] shots_tc_i,
  input  logic [NW-1:0] steps_tc_i,
  output logic [NW-1:0] step_idx_o,
  output logic          step_wrap_o,
  output logic          last_step_o
);

  logic [NW-1:0] shot_q, shot_d;
  logic [NW-1:0] step_q, step_d;

  always_comb begin
    shot_d = shot_q;
    step_d = step_q;
    if (clr_i) begin
      shot_d = '0;
      step_d = '0;
    end else if (adv_i) begin
      if (shot_q < shots_tc_i) begin
        shot_d = shot_q + NW'(1);
      end else begin
        shot_d = '0;
        // Wrapping the step index back to 0 is how loop mode restarts.
        if (step_q < steps_tc_i) begin
          step_d = step_q + NW'(1);
        end else begin
          step_d = '0;
        end
      end
    end else begin
      shot_d = shot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shot_q <= '0;
      step_q <= '0;
    end else begin
      shot_q <= shot_d;
      step_q <= step_d;
    end
  end

  assign step_idx_o  = step_q;
  assign step_wrap_o = (shot_q >= shots_tc_i);
  assign last_step_o = (step_q >= steps_tc_i);

endmodule

// File: rtl/delay_sweep_sched.sv
// Inter-pulse delay sweep scheduler: applies new sweep values only at the
// generator's period boundaries (cycle_start).
module delay_sweep_sched
  import delay_sweep_sched_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rxd,
  input  logic [DW-1:0] cfg_del_start,
  input  logic [DW-1:0] cfg_del_step,
  input  logic [NW-1:0] cfg_steps,
  input  logic [NW-1:0] cfg_shots,
  input  logic          cfg_loop,
  input  logic          enable,
  input  logic          cycle_start,
  output logic [DW-1:0] del_out,
  output logic [NW-1:0] step_idx,
  output logic          step_strobe,
  output logic          busy,
  output logic          done,
  output logic          sat
);

  state_t        state_q, state_d;
  logic [DW-1:0] start_q, start_d, step_q, step_d;
  logic [NW-1:0] steps_tc_q, steps_tc_d, shots_tc_q, shots_tc_d;
  logic          loop_q, loop_d;
  logic [DW-1:0] del_q, del_d;
  logic          strobe_q, strobe_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic          cnt_clr_s, cnt_adv_s, step_wrap_s, last_step_s;
  logic          adv_s;
  logic [DW:0]   sum_s;

  assign adv_s = cycle_start & enable;
  assign sum_s = sat_add(del_q, step_q);

  sweep_counter #(.NW(NW)) u_cnt (
    .clk         (clk),
    .resetn      (resetn),
    .clr_i       (cnt_clr_s),
    .adv_i       (cnt_adv_s),
    .shots_tc_i  (shots_tc_q),
    .steps_tc_i  (steps_tc_q),
    .step_idx_o  (step_idx),
    .step_wrap_o (step_wrap_s),
    .last_step_o (last_step_s)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    step_d     = step_q;
    steps_tc_d = steps_tc_q;
    shots_tc_d = shots_tc_q;
    loop_d     = loop_q;
    del_d      = del_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    sat_d      = sat_q;
    cnt_clr_s  = 1'b0;
    cnt_adv_s  = 1'b0;
    if (rxd) begin
      // Counts of 0 behave as 1, so the stored terminal count is max(n,1)-1.
      start_d    = cfg_del_start;
      step_d     = cfg_del_step;
      steps_tc_d = (cfg_steps == '0) ? '0 : cfg_steps - NW'(1);
      shots_tc_d = (cfg_shots == '0) ? '0 : cfg_shots - NW'(1);
      loop_d     = cfg_loop;
      done_d     = 1'b0;
      sat_d      = 1'b0;
      busy_d     = 1'b0;
      state_d    = ST_ARM;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ARM: begin
          if (adv_s) begin
            del_d     = start_q;
            cnt_clr_s = 1'b1;
            strobe_d  = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_RUN: begin
          if (!adv_s) begin
            state_d = ST_RUN;
          end else if (!step_wrap_s) begin
            cnt_adv_s = 1'b1;
          end else if (!last_step_s) begin
            cnt_adv_s = 1'b1;
            del_d     = sum_s[DW-1:0];
            sat_d     = sat_q | sum_s[DW];
            strobe_d  = 1'b1;
          end else if (loop_q) begin
            cnt_adv_s = 1'b1;
            del_d     = start_q;
            strobe_d  = 1'b1;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      step_q     <= '0;
      steps_tc_q <= '0;
      shots_tc_q <= '0;
      loop_q     <= 1'b0;
      del_q      <= '0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      step_q     <= step_d;
      steps_tc_q <= steps_tc_d;
      shots_tc_q <= shots_tc_d;
      loop_q     <= loop_d;
      del_q      <= del_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign del_out     = del_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_delay_sweep_sched.sv
// Directed bench for delay_sweep_sched; inputs change and outputs are
// sampled on the falling edge, expected values are hand-derived.
module tb_delay_sweep_sched;

  logic        clk = 1'b0;
  logic        resetn, rxd, cfg_loop, enable, cycle_start;
  logic [15:0] cfg_del_start, cfg_del_step, del_out;
  logic [7:0]  cfg_steps, cfg_shots, step_idx;
  logic        step_strobe, busy, done, sat;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobe;

  always #5 clk = ~clk;

  delay_sweep_sched dut (
    .clk(clk), .resetn(resetn), .rxd(rxd),
    .cfg_del_start(cfg_del_start), .cfg_del_step(cfg_del_step),
    .cfg_steps(cfg_steps), .cfg_shots(cfg_shots), .cfg_loop(cfg_loop),
    .enable(enable), .cycle_start(cycle_start),
    .del_out(del_out), .step_idx(step_idx), .step_strobe(step_strobe),
    .busy(busy), .done(done), .sat(sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {del_out, step_idx, strobe, busy, done, sat}.
  task automatic chk_all(input string tag, input logic [15:0] d, input logic [7:0] s,
                         input logic st, input logic b, input logic dn, input logic sa);
    chk(tag, {4'h0, del_out, step_idx, step_strobe, busy, done, sat},
             {4'h0, d, s, st, b, dn, sa});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cs_pulse();
    cycle_start = 1'b1;
    @(negedge clk);
    cycle_start = 1'b0;
    if (step_strobe) n_strobe++;
  endtask

  task automatic send_cfg(input logic [15:0] st, input logic [15:0] sp,
                          input logic [7:0] ns, input logic [7:0] nh, input logic lp,
                          input logic with_cs);
    cfg_del_start = st; cfg_del_step = sp; cfg_steps = ns; cfg_shots = nh; cfg_loop = lp;
    rxd = 1'b1; cycle_start = with_cs;
    @(negedge clk);
    rxd = 1'b0; cycle_start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rxd = 1'b0; enable = 1'b1; cycle_start = 1'b0; cfg_loop = 1'b0;
    cfg_del_start = 16'd0; cfg_del_step = 16'd0; cfg_steps = 8'd0; cfg_shots = 8'd0;
    n_strobe = 0;

    // Reset, then cycle_start without configuration must do nothing.
    idle(2);
    chk_all("reset", 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    cs_pulse(); idle(1); cs_pulse();
    chk_all("idle_no_cfg", 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic single-pass sweep: 100,100,110,110,120,120 then done.
    send_cfg(16'd100, 16'd10, 8'd3, 8'd2, 1'b0, 1'b0);
    chk_all("arm", 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_strobe = 0;
    cs_pulse(); chk_all("b_p1", 16'd100, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);    chk_all("b_p1_strobe_off", 16'd100, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p2", 16'd100, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p3", 16'd110, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p4", 16'd110, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p5", 16'd120, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p6", 16'd120, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("b_p7_done", 16'd120, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cs_pulse(); chk_all("b_p8_ignored", 16'd120, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("b_strobe_count", n_strobe, 32'd3);

    // Loop mode: rxd holds del_out/step_idx and clears done; sweep restarts.
    send_cfg(16'd100, 16'd10, 8'd3, 8'd2, 1'b1, 1'b0);
    chk_all("l_arm_hold", 16'd120, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cs_pulse(); chk_all("l_p1", 16'd100, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cs_pulse();
    chk_all("l_p6", 16'd120, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("l_p7_restart", 16'd100, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Saturation at the top of the delay range.
    send_cfg(16'hFFF0, 16'h0020, 8'd2, 8'd1, 1'b0, 1'b0);
    cs_pulse(); chk_all("s_p1", 16'hFFF0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("s_p2_sat", 16'hFFFF, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    cs_pulse(); chk_all("s_p3_done", 16'hFFFF, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Zero counts behave as one step of one shot; rxd clears sat.
    send_cfg(16'd50, 16'd5, 8'd0, 8'd0, 1'b0, 1'b0);
    chk_all("z_arm_sat_clr", 16'hFFFF, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cs_pulse(); chk_all("z_p1", 16'd50, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("z_p2_done", 16'd50, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // rxd colliding with cycle_start mid-run: config wins, del_out held.
    send_cfg(16'd100, 16'd10, 8'd3, 8'd2, 1'b0, 1'b0);
    cs_pulse(); cs_pulse(); cs_pulse();
    chk_all("c_pre", 16'd110, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_cfg(16'd200, 16'd1, 8'd2, 8'd1, 1'b0, 1'b1);
    chk_all("c_collide", 16'd110, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cs_pulse(); chk_all("c_p1", 16'd200, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Freeze with enable low, then resume in sequence.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cs_pulse();
    chk_all("f_frozen", 16'd200, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    cs_pulse(); chk_all("f_resume", 16'd201, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cs_pulse(); chk_all("f_done", 16'd201, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run clears everything and returns to IDLE.
    send_cfg(16'd100, 16'd10, 8'd3, 8'd2, 1'b0, 1'b0);
    cs_pulse(); cs_pulse(); cs_pulse();
    chk_all("r_pre", 16'd110, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    resetn = 1'b0;
    idle(1);
    chk_all("r_mid_run", 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    cs_pulse(); chk_all("r_idle_after", 16'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
